// File: rtl/branch_gshare_spec.sv
// GShare direction predictor: PHT of saturating counters indexed by PC xor speculative
// global history, sweep-initialised after reset, with EX-side training, history repair and stats.
module branch_gshare_spec #(
    parameter int PHT_IDX_BITS = 8,
    parameter int CTR_BITS     = 2,
    parameter int GHR_BITS     = 8,
    parameter int CNT_BITS     = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_valid,
    input  logic                    if_is_branch,
    input  logic [31:0]             pc_if,
    output logic                    pred_taken_if,
    output logic [PHT_IDX_BITS-1:0] pht_idx_if,
    output logic [GHR_BITS-1:0]     ghr_snap_if,
    output logic                    pred_ready,
    input  logic                    ex_update_en,
    input  logic                    ex_actual_taken,
    input  logic                    ex_pred_taken,
    input  logic [PHT_IDX_BITS-1:0] pht_idx_ex,
    input  logic [GHR_BITS-1:0]     ghr_snap_ex,
    output logic                    ex_mispredict,
    output logic [CNT_BITS-1:0]     stat_updates,
    output logic [CNT_BITS-1:0]     stat_mispred
);

    localparam int PHT_SIZE = 1 << PHT_IDX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b0, {(CTR_BITS-1){1'b1}}};
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [PHT_IDX_BITS-1:0] PTR_LAST = '1;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                  state, state_nxt;
    logic                    run;
    logic [PHT_IDX_BITS-1:0] init_ptr;
    logic [CTR_BITS-1:0]     pht [PHT_SIZE];
    logic [GHR_BITS-1:0]     spec_ghr;
    logic [CNT_BITS-1:0]     stat_updates_p1;
    logic [CNT_BITS-1:0]     stat_mispred_p1;
    logic                    mispred_p1;
    logic                    accept;
    logic                    mispred;
    logic                    unused_pc_bits;

    function automatic logic [CTR_BITS-1:0] sat_ctr(input logic [CTR_BITS-1:0] c, input logic up);
        if (up)
            return (c == CTR_MAX) ? c : c + CTR_BITS'(1);
        else
            return (c == '0) ? c : c - CTR_BITS'(1);
    endfunction

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] c);
        return (&c) ? c : c + CNT_BITS'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_INIT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:  if (init_ptr == PTR_LAST) state_nxt = S_RUN;
            S_RUN:   state_nxt = S_RUN;
            default: state_nxt = S_INIT;
        endcase
    end

    always_comb begin
        run           = (state == S_RUN);
        pred_ready    = run;
        pred_taken_if = run && pht[pht_idx_if][CTR_BITS-1];
    end

    assign pht_idx_if     = pc_if[PHT_IDX_BITS+1:2] ^ PHT_IDX_BITS'(spec_ghr);
    assign ghr_snap_if    = spec_ghr;
    assign unused_pc_bits = ^{pc_if[31:PHT_IDX_BITS+2], pc_if[1:0]};

    assign accept  = run && ex_update_en;
    assign mispred = accept && (ex_actual_taken != ex_pred_taken);

    always_ff @(posedge clk) begin
        if (rst)
            init_ptr <= '0;
        else if (!run)
            init_ptr <= init_ptr + PHT_IDX_BITS'(1);
    end

    // PHT contents are data: rebuilt by the INIT sweep rather than by reset
    always_ff @(posedge clk) begin
        if (!run)
            pht[init_ptr] <= CTR_INIT;
        else if (ex_update_en)
            pht[pht_idx_ex] <= sat_ctr(pht[pht_idx_ex], ex_actual_taken);
    end

    // A mispredict repair wins over a same-cycle IF shift, which is on the wrong path
    always_ff @(posedge clk) begin
        if (rst)
            spec_ghr <= '0;
        else if (mispred)
            spec_ghr <= {ghr_snap_ex[GHR_BITS-2:0], ex_actual_taken};
        else if (run && if_valid && if_is_branch)
            spec_ghr <= {spec_ghr[GHR_BITS-2:0], pred_taken_if};
    end

    // EX result stage: registered mispredict pulse and saturating statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            mispred_p1      <= 1'b0;
            stat_updates_p1 <= '0;
            stat_mispred_p1 <= '0;
        end else begin
            mispred_p1 <= mispred;
            if (accept)
                stat_updates_p1 <= sat_inc(stat_updates_p1);
            if (mispred)
                stat_mispred_p1 <= sat_inc(stat_mispred_p1);
        end
    end

    assign ex_mispredict = mispred_p1;
    assign stat_updates  = stat_updates_p1;
    assign stat_mispred  = stat_mispred_p1;

endmodule

// File: tb/tb_branch_gshare_spec.sv
// Scoreboard bench for branch_gshare_spec: a table-level predictor model forecasts each
// cycle's outputs, a negedge monitor compares them against the DUT.
module tb_branch_gshare_spec;

    localparam int IDX  = 8;
    localparam int CTRB = 2;
    localparam int GHRB = 8;
    localparam int CNTB = 8;
    localparam int N     = 1 << IDX;
    localparam int GMASK = (1 << GHRB) - 1;
    localparam int CMAX  = (1 << CTRB) - 1;
    localparam int CINIT = (1 << (CTRB - 1)) - 1;
    localparam longint SMAX = (64'd1 << CNTB) - 1;

    logic            clk;
    logic            rst;
    logic            if_valid;
    logic            if_is_branch;
    logic [31:0]     pc_if;
    logic            pred_taken_if;
    logic [IDX-1:0]  pht_idx_if;
    logic [GHRB-1:0] ghr_snap_if;
    logic            pred_ready;
    logic            ex_update_en;
    logic            ex_actual_taken;
    logic            ex_pred_taken;
    logic [IDX-1:0]  pht_idx_ex;
    logic [GHRB-1:0] ghr_snap_ex;
    logic            ex_mispredict;
    logic [CNTB-1:0] stat_updates;
    logic [CNTB-1:0] stat_mispred;

    branch_gshare_spec #(
        .PHT_IDX_BITS(IDX), .CTR_BITS(CTRB), .GHR_BITS(GHRB), .CNT_BITS(CNTB)
    ) dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_is_branch(if_is_branch), .pc_if(pc_if),
        .pred_taken_if(pred_taken_if), .pht_idx_if(pht_idx_if), .ghr_snap_if(ghr_snap_if),
        .pred_ready(pred_ready),
        .ex_update_en(ex_update_en), .ex_actual_taken(ex_actual_taken),
        .ex_pred_taken(ex_pred_taken), .pht_idx_ex(pht_idx_ex), .ghr_snap_ex(ghr_snap_ex),
        .ex_mispredict(ex_mispredict), .stat_updates(stat_updates), .stat_mispred(stat_mispred)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit     chk;
        bit     ready;
        bit     pred;
        int     idx;
        int     snap;
        bit     mis;
        longint upd;
        longint mp;
    } exp_t;

    exp_t   q[$];
    int     m_pht[N];
    int     m_ghr;
    int     m_init_left;
    bit     m_mis;
    bit     m_known;
    longint m_upd;
    longint m_mp;
    int     checks;
    int     passed;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp)
            passed++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // One clock cycle: drive inputs, forecast this cycle's outputs, then advance the model
    task automatic step(input bit r, input bit iv, input bit ib, input logic [31:0] pc,
                        input bit ue, input bit at, input bit pt, input int ix, input int sn);
        exp_t e;
        int   ng;
        @(posedge clk);
        #1;
        rst = r; if_valid = iv; if_is_branch = ib; pc_if = pc;
        ex_update_en = ue; ex_actual_taken = at; ex_pred_taken = pt;
        pht_idx_ex = IDX'(ix); ghr_snap_ex = GHRB'(sn);

        e.chk   = m_known;
        e.ready = (m_init_left == 0);
        e.idx   = ((pc >> 2) % N) ^ m_ghr;
        e.pred  = e.ready && (m_pht[e.idx] > CINIT);
        e.snap  = m_ghr;
        e.mis   = m_mis;
        e.upd   = m_upd;
        e.mp    = m_mp;
        q.push_back(e);

        if (r) begin
            m_known = 1; m_init_left = N; m_ghr = 0; m_mis = 0; m_upd = 0; m_mp = 0;
            foreach (m_pht[i]) m_pht[i] = CINIT;
        end else if (m_init_left > 0) begin
            m_init_left--;
        end else begin
            ng = m_ghr;
            if (iv && ib) ng = ((m_ghr * 2) + int'(e.pred)) & GMASK;
            m_mis = 0;
            if (ue) begin
                if (at) m_pht[ix] = (m_pht[ix] < CMAX) ? m_pht[ix] + 1 : CMAX;
                else    m_pht[ix] = (m_pht[ix] > 0) ? m_pht[ix] - 1 : 0;
                m_upd = (m_upd < SMAX) ? m_upd + 1 : SMAX;
                if (at != pt) begin
                    m_mp  = (m_mp < SMAX) ? m_mp + 1 : SMAX;
                    m_mis = 1;
                    ng    = ((sn * 2) + int'(at)) & GMASK;
                end
            end
            m_ghr = ng;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.chk) begin
                    check("pred_ready", pred_ready, e.ready);
                    check("pred_taken_if", pred_taken_if, e.pred);
                    check("pht_idx_if", pht_idx_if, e.idx);
                    check("ghr_snap_if", ghr_snap_if, e.snap);
                    check("ex_mispredict", ex_mispredict, e.mis);
                    check("stat_updates", stat_updates, e.upd);
                    check("stat_mispred", stat_mispred, e.mp);
                end
            end
        end
    end

    initial begin : driver
        clk = 0; rst = 0; if_valid = 0; if_is_branch = 0; pc_if = 0;
        ex_update_en = 0; ex_actual_taken = 0; ex_pred_taken = 0; pht_idx_ex = 0; ghr_snap_ex = 0;
        m_known = 0; m_init_left = N; m_ghr = 0; m_mis = 0; m_upd = 0; m_mp = 0;
        checks = 0; passed = 0;
        foreach (m_pht[i]) m_pht[i] = CINIT;

        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        // Idle through INIT with EX/IF activity that must be ignored, then idle in RUN
        for (int i = 0; i < 200; i++) step(0, 1, 1, $urandom, 1, 1, 0, $urandom_range(0, N - 1), $urandom);
        idle(80);

        // Train pc 0x100 with fixed history: counter 01 -> 10 -> 11 -> 11
        for (int i = 0; i < 3; i++) step(0, 1, 0, 32'h100, 1, 1, 1, 'h40, 0);
        step(0, 1, 0, 32'h100, 0, 0, 0, 0, 0);

        // Mispredict repair from snapshot 0x5A with actual taken
        step(0, 1, 1, 32'h200, 0, 0, 0, 0, 0);
        step(0, 0, 0, 32'h0, 1, 1, 0, 'h10, 'h5A);
        idle(2);

        // Same-cycle IF branch and EX mispredict: repair wins
        step(0, 1, 1, 32'h300, 1, 0, 1, 5, 'h33);
        idle(2);

        // Reset mid-INIT
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(100);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(260);

        // Randomised traffic; enough updates to drive the 8-bit stats into saturation
        for (int i = 0; i < 2000; i++)
            step(0, 1'($urandom), 1'($urandom), ($urandom & 32'hFFFF_FC00) | ($urandom_range(0, 63) << 2),
                 ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 31), $urandom_range(0, 255));
        idle(4);

        @(negedge clk);
        #1;
        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        checks++;
        if (q.size() == 0)
            passed++;
        else
            $display("FAIL drain: got %0d pending expected 0", q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
